// File: rtl/adder11_rr_sched_pkg.sv
// Shared widths and FSM encoding for the
// round-robin adder11 scheduler.
package adder11_rr_sched_pkg;

  localparam int ADD_W = 11;
  localparam int SUM_W = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/adder11.sv
// 11-bit ripple-carry adder with carry-out
// as bit 11 of the sum.
module adder11 (
  input  logic [10:0] a,
  input  logic [10:0] b,
  output logic [11:0] sum
);

  logic [11:0] c;

  assign c[0] = 1'b0;

  for (genvar i = 0; i < 11; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i + 1] = (a[i] & b[i])
                    | (c[i] & (a[i] ^ b[i]));
  end

  assign sum[11] = c[11];

endmodule

// File: rtl/adder11_rr_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first valid
// requester at or after rr_ptr wins.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]  rr_ptr,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_id,
  output logic             grant_vld
);

  // Scan from farthest to nearest so the nearest valid wins.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_valid[(int'(rr_ptr) + k) % N_REQ]) begin
        grant = '0;
        grant[(int'(rr_ptr) + k) % N_REQ] = 1'b1;
        grant_id = ID_W'((int'(rr_ptr) + k) % N_REQ);
      end
    end
  end

  assign grant_vld = |req_valid;

endmodule

// File: rtl/adder11_rr_sched.sv
// Shares one adder11 among N_REQ requesters with
// round-robin arbitration and a 3-state FSM.
module adder11_rr_sched
  import adder11_rr_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*ADD_W-1:0] req_a,
  input  logic [N_REQ*ADD_W-1:0] req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [SUM_W-1:0]       rsp_sum
);

  state_t             state;
  state_t             state_nx;
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    op_id;
  logic [ADD_W-1:0]   op_a;
  logic [ADD_W-1:0]   op_b;
  logic [SUM_W-1:0]   sum;
  logic [N_REQ-1:0]   gnt;
  logic [ID_W-1:0]    gnt_id;
  logic               gnt_vld;
  logic               accept;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (gnt),
    .grant_id  (gnt_id),
    .grant_vld (gnt_vld)
  );

  adder11 u_add (
    .a   (op_a),
    .b   (op_b),
    .sum (sum)
  );

  // Next state, request acceptance and ready decode.
  always_comb begin
    state_nx  = state;
    req_ready = '0;
    accept    = 1'b0;
    unique case (state)
      IDLE: begin
        if (!rst && gnt_vld) begin
          req_ready = gnt;
          accept    = 1'b1;
          state_nx  = ADD;
        end
      end
      ADD:  state_nx = RESP;
      RESP: if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State, operand, result and pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      op_id     <= '0;
      op_a      <= '0;
      op_b      <= '0;
      rsp_id    <= '0;
      rsp_sum   <= '0;
      rsp_valid <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        op_id <= gnt_id;
        op_a  <= req_a[gnt_id*ADD_W +: ADD_W];
        op_b  <= req_b[gnt_id*ADD_W +: ADD_W];
      end
      if (state == ADD) begin
        rsp_sum   <= sum;
        rsp_id    <= op_id;
        rsp_valid <= 1'b1;
      end
      if (state == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
        rr_ptr    <= (rsp_id == ID_W'(N_REQ - 1))
                   ? '0 : rsp_id + ID_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_adder11_rr_sched.sv
// Randomised and directed bench for adder11_rr_sched
// against a transaction-level model.
module tb_adder11_rr_sched;

  localparam int N = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*11-1:0] req_a;
  logic [N*11-1:0] req_b;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [1:0]      rsp_id;
  logic [11:0]     rsp_sum;

  adder11_rr_sched #(.N_REQ(N), .ID_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Transaction model: one op in flight, its age in
  // cycles since acceptance, and the fairness pointer.
  bit m_busy = 0;
  int m_age  = 0;
  int m_id   = 0;
  int m_sum  = 0;
  int m_ptr  = 0;
  int obs[$];

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d",
                  name, act, exp);
  endtask

  function automatic int winner();
    for (int k = 0; k < N; k++)
      if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  function automatic int op_a(int i);
    return int'(req_a[11*i +: 11]);
  endfunction

  function automatic int op_b(int i);
    return int'(req_b[11*i +: 11]);
  endfunction

  task automatic set_op(int i, int a, int b);
    req_a[11*i +: 11] = 11'(a);
    req_b[11*i +: 11] = 11'(b);
  endtask

  // One cycle: compare against the model, advance the
  // model over the coming edge, then cross that edge.
  task automatic step();
    int w;
    logic [N-1:0] exp_rdy;
    bit exp_rv;
    #1;
    w = winner();
    exp_rdy = '0;
    if (!m_busy && !rst && w >= 0) exp_rdy[w] = 1'b1;
    exp_rv = m_busy && m_age >= 1;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
    if (exp_rv) begin
      chk("rsp_id", 32'(rsp_id), 32'(m_id));
      chk("rsp_sum", 32'(rsp_sum), 32'(m_sum));
    end
    if (rsp_valid === 1'b1 && rsp_ready && !rst)
      obs.push_back(int'(rsp_id));
    if (rst) begin
      m_busy = 0;
      m_ptr  = 0;
    end else if (!m_busy) begin
      if (w >= 0) begin
        m_busy = 1;
        m_age  = 0;
        m_id   = w;
        m_sum  = op_a(w) + op_b(w);
      end
    end else if (m_age == 0) begin
      m_age = 1;
    end else if (rsp_ready) begin
      m_busy = 0;
      m_ptr  = (m_id + 1) % N;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(int cycles);
    rst = 1'b1;
    for (int i = 0; i < cycles; i++) step();
    rst = 1'b0;
  endtask

  // Single op from requester id; literal latency checks.
  task automatic single(int id, int a, int b, int exp_sum);
    req_valid = '0;
    req_valid[id] = 1'b1;
    set_op(id, a, b);
    rsp_ready = 1'b1;
    step();
    req_valid = '0;
    chk("lat_add_rv", 32'(rsp_valid), 32'd0);
    step();
    chk("lat_rv", 32'(rsp_valid), 32'd1);
    chk("lit_id", 32'(rsp_id), 32'(id));
    chk("lit_sum", 32'(rsp_sum), 32'(exp_sum));
    step();
    chk("rsp_done", 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    logic [11:0] h_sum;
    logic [1:0]  h_id;
    rst = 1'b1;
    req_valid = 4'b1111;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b0;
    @(posedge clk);
    #1;

    do_reset(2);
    chk("rst_rdy", 32'(req_ready & {N{rst}}), 32'd0);
    chk("rst_rv", 32'(rsp_valid), 32'd0);
    chk("rst_sum", 32'(rsp_sum), 32'd0);

    req_valid = '0;
    step();
    single(1, 1023, 1, 1024);
    single(2, 2047, 2047, 4094);
    single(3, 0, 0, 0);

    do_reset(1);
    obs.delete();
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    for (int i = 0; i < N; i++)
      set_op(i, $urandom_range(2047), $urandom_range(2047));
    for (int i = 0; i < 15; i++) step();
    chk("rr_count", 32'(obs.size()), 32'd5);
    for (int i = 0; i < 5 && i < obs.size(); i++)
      chk("rr_order", 32'(obs[i]), 32'(i % N));

    do_reset(1);
    req_valid = 4'b1111;
    rsp_ready = 1'b0;
    set_op(0, 1500, 600);
    step();
    step();
    h_sum = rsp_sum;
    h_id  = rsp_id;
    chk("bp_sum", 32'(h_sum), 32'd2100);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_hold_sum", 32'(rsp_sum), 32'(h_sum));
      chk("bp_hold_id", 32'(rsp_id), 32'(h_id));
      chk("bp_rdy0", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    step();
    chk("bp_idle", 32'(req_ready), 32'b0010);

    do_reset(1);
    req_valid = 4'b0100;
    set_op(2, 77, 88);
    step();
    req_valid = '0;
    do_reset(1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("mid_rst_rv", 32'(rsp_valid), 32'd0);
    end
    req_valid = 4'b1111;
    #1;
    chk("mid_rst_ptr", 32'(req_ready), 32'b0001);

    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(199) == 0);
      req_valid = N'($urandom);
      rsp_ready = ($urandom_range(3) != 0);
      for (int i = 0; i < N; i++)
        set_op(i, $urandom_range(2047), $urandom_range(2047));
      step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
